// File: rtl/lock_attempt_ctrl_if.sv
// rtl/lock_attempt_ctrl_if.sv - code entry, relock and countdown handshake bundle for the lock supervisor
interface lock_attempt_ctrl_if #(
    parameter int CODE_W = 16
);
    logic              code_valid;
    logic [CODE_W-1:0] code_in;
    logic              relock;
    logic              rst_all;
    logic              cd_start;
    logic              unlocked;
    logic              locked_out;
    logic              err_pulse;
    logic [1:0]        fail_cnt;
    logic              timeout;

    modport master (
        output code_valid, code_in, relock, rst_all,
        input  cd_start, unlocked, locked_out, err_pulse, fail_cnt, timeout
    );

    modport slave (
        input  code_valid, code_in, relock, rst_all,
        output cd_start, unlocked, locked_out, err_pulse, fail_cnt, timeout
    );
endinterface

// File: rtl/lock_attempt_ctrl.sv
// rtl/lock_attempt_ctrl.sv - passcode check, consecutive-failure count and lockout/countdown initiator
module lock_attempt_ctrl #(
    parameter int                CODE_W   = 16,
    parameter logic [CODE_W-1:0] PASSCODE = 16'h1234,
    parameter int                MAX_FAIL = 3,
    parameter int                WAIT_MAX = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    lock_attempt_ctrl_if.slave    bus
);
    localparam int          WCNT_W    = $clog2(WAIT_MAX);
    localparam logic [1:0]  MAX_F     = 2'(MAX_FAIL);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        OPEN     = 2'd1,
        LK_START = 2'd2,
        LK_WAIT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [1:0]        fail_q, fail_n;
    logic [WCNT_W-1:0] wcnt, wcnt_n;
    logic              timeout_q, timeout_n;
    logic              err_n;
    logic              err_q, cd_start_q, unlocked_q, locked_out_q;

    // Next-state logic: code evaluation in LOCKED, relock in OPEN, rst_all wait with timeout in LK_WAIT.
    always_comb begin
        state_n   = state;
        fail_n    = fail_q;
        wcnt_n    = wcnt;
        timeout_n = timeout_q;
        err_n     = 1'b0;
        case (state)
            LOCKED: begin
                if (bus.code_valid) begin
                    if (bus.code_in == PASSCODE) begin
                        state_n = OPEN;
                        fail_n  = 2'd0;
                    end else begin
                        err_n = 1'b1;
                        if (fail_q < MAX_F) begin
                            fail_n = fail_q + 2'd1;
                        end
                        if (fail_n == MAX_F) begin
                            state_n = LK_START;
                        end
                    end
                end
            end
            OPEN: begin
                if (bus.relock) begin
                    state_n = LOCKED;
                end
            end
            LK_START: begin
                state_n = LK_WAIT;
                wcnt_n  = '0;
            end
            LK_WAIT: begin
                if (bus.rst_all) begin
                    state_n = LOCKED;
                    fail_n  = 2'd0;
                    wcnt_n  = '0;
                end else if (wcnt == WAIT_LAST) begin
                    state_n   = LK_START;
                    timeout_n = 1'b1;
                    wcnt_n    = '0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            default: state_n = LOCKED;
        endcase
    end

    // State and registered outputs; outputs derive from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOCKED;
            fail_q       <= 2'd0;
            wcnt         <= '0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
            cd_start_q   <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state        <= state_n;
            fail_q       <= fail_n;
            wcnt         <= wcnt_n;
            timeout_q    <= timeout_n;
            err_q        <= err_n;
            cd_start_q   <= (state_n == LK_START);
            unlocked_q   <= (state_n == OPEN);
            locked_out_q <= (state_n == LK_START) || (state_n == LK_WAIT);
        end
    end

    assign bus.cd_start   = cd_start_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.locked_out = locked_out_q;
    assign bus.err_pulse  = err_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// tb/tb_lock_attempt_ctrl.sv - randomized and directed check of lock_attempt_ctrl against a reference model
module tb_lock_attempt_ctrl;
    localparam logic [15:0] PASS = 16'h1234;
    localparam int          MAXF = 3;
    localparam int          WMAX = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // reference model: open flag, lockout flag and cycles elapsed in the current lockout round
    bit m_open, m_lk, m_to, m_err;
    int m_phase, m_fails;
    int cd_seen;

    lock_attempt_ctrl_if #(.CODE_W(16)) bus();

    lock_attempt_ctrl #(
        .CODE_W(16), .PASSCODE(PASS), .MAX_FAIL(MAXF), .WAIT_MAX(WMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_lk = 0; m_to = 0; m_err = 0; m_phase = 0; m_fails = 0;
    endtask

    // one clock edge of behaviour, using inputs as they were at the edge
    task automatic model_step();
        m_err = 0;
        if (m_lk) begin
            if (m_phase == 0) m_phase = 1;
            else if (bus.rst_all) begin m_lk = 0; m_fails = 0; end
            else if (m_phase == WMAX) begin m_phase = 0; m_to = 1; end
            else m_phase++;
        end else if (m_open) begin
            if (bus.relock) m_open = 0;
        end else if (bus.code_valid) begin
            if (bus.code_in == PASS) begin m_open = 1; m_fails = 0; end
            else begin
                m_err = 1;
                m_fails++;
                if (m_fails == MAXF) begin m_lk = 1; m_phase = 0; end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".unlocked"},   32'(bus.unlocked),   32'(m_open));
        check({ctx, ".locked_out"}, 32'(bus.locked_out), 32'(m_lk));
        check({ctx, ".cd_start"},   32'(bus.cd_start),   32'(m_lk && m_phase == 0));
        check({ctx, ".err_pulse"},  32'(bus.err_pulse),  32'(m_err));
        check({ctx, ".fail_cnt"},   32'(bus.fail_cnt),   32'(m_fails));
        check({ctx, ".timeout"},    32'(bus.timeout),    32'(m_to));
    endtask

    task automatic step(input string ctx, input bit v, input logic [15:0] code, input bit rl, input bit ra);
        bus.code_valid = v;
        bus.code_in    = code;
        bus.relock     = rl;
        bus.rst_all    = ra;
        @(posedge clk);
        model_step();
        if (bus.cd_start) cd_seen++;
        #1;
        check_all(ctx);
        bus.code_valid = 0;
        bus.relock     = 0;
        bus.rst_all    = 0;
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx, 0, 16'h0, 0, 0);
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic async_reset(input string ctx);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all(ctx);
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cd_seen = 0;
        bus.code_valid = 0; bus.code_in = 0; bus.relock = 0; bus.rst_all = 0;
        model_reset();
        rst = 1;
        #12;
        check_all("reset");
        #10;
        rst = 0;

        // correct code opens, relock closes
        step("open", 1, PASS, 0, 0);
        idle("open_hold", 2);
        step("relock", 0, 16'h0, 1, 0);

        // two failures then the correct code clears the count
        step("wrong1", 1, 16'h0001, 0, 0);
        step("wrong2", 1, 16'h0002, 0, 0);
        check("fail_cnt_two", 32'(bus.fail_cnt), 32'd2);
        step("recover", 1, PASS, 0, 0);
        step("relock2", 0, 16'h0, 1, 0);

        // three back-to-back failures -> lockout, code ignored in LK_WAIT, rst_all releases
        cd_seen = 0;
        step("lk1", 1, 16'h1111, 0, 0);
        step("lk2", 1, 16'h2222, 0, 0);
        step("lk3", 1, 16'h3333, 0, 0);
        step("lk_start_strobe", 1, PASS, 0, 1);
        step("lk_wait_code", 1, PASS, 1, 0);
        idle("lk_wait", 2);
        step("rst_all", 0, 16'h0, 0, 1);
        check("cd_start_once", 32'(cd_seen), 32'd1);

        // lockout with no rst_all: timeout and a re-pulsed cd_start, then release
        cd_seen = 0;
        for (int i = 0; i < 3; i++) step("to_wrong", 1, 16'h00F0, 0, 0);
        idle("to_wait", WMAX + 3);
        check("timeout_set", 32'(bus.timeout), 32'd1);
        check("cd_start_twice", 32'(cd_seen), 32'd2);
        step("to_release", 0, 16'h0, 0, 1);
        idle("to_after", 1);

        // rst_all ignored in LOCKED and OPEN
        step("ra_locked", 0, 16'h0, 0, 1);
        step("ra_open0", 1, PASS, 0, 0);
        step("ra_open", 0, 16'h0, 0, 1);
        step("ra_relock", 0, 16'h0, 1, 0);

        // async reset in the middle of LK_WAIT, then normal unlock
        for (int i = 0; i < 3; i++) step("ar_wrong", 1, 16'hBEEF, 0, 0);
        idle("ar_wait", 3);
        async_reset("async_rst");
        step("ar_open", 1, PASS, 0, 0);
        step("ar_relock", 0, 16'h0, 1, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end else begin
                step("rand",
                     $urandom_range(0, 2) == 0,
                     ($urandom_range(0, 1) == 0) ? PASS : 16'($urandom),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 11) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_attempt_ctrl.md
Name: lock_attempt_ctrl

Overview:
- Attempt supervisor for the digital lock. Compares each entered code against the stored passcode, drives the unlocked indication and counts consecutive failures.
- On the MAX_FAIL-th consecutive failure it enters lockout and fires a start pulse to the 3-to-0 countdown block.
- It then waits for that block's rst_all completion pulse before it accepts codes again. It is the initiator side of the countdown start/rst_all exchange.

Parameters:
- CODE_W, 16, width of entered code and passcode.
- PASSCODE, 16'h1234, correct code (CODE_W bits).
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (1..3).
- WAIT_MAX, 64, cycles allowed in lockout for rst_all before a timeout flag is raised (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe: code_in holds a completed entry.
- code_in  in  CODE_W  entered code, sampled only when code_valid=1.
- relock  in  1  level; returns the lock from OPEN to LOCKED.
- rst_all  in  1  completion pulse from the countdown block.
- cd_start  out  1  one-cycle pulse that starts the countdown.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in lockout (LK_START or LK_WAIT).
- err_pulse  out  1  one-cycle pulse per wrong code.
- fail_cnt  out  2  consecutive-failure count, 0..MAX_FAIL.
- timeout  out  1  sticky flag: rst_all missing for WAIT_MAX cycles.

Behaviour:
- All outputs are registered. Reset (asynchronous, active-high) forces state=LOCKED and every output to 0.
- State LOCKED, on code_valid:
  - If code_in==PASSCODE: go to OPEN and clear fail_cnt.
  - Otherwise: err_pulse=1 next cycle and fail_cnt+1.
  - If the new fail_cnt==MAX_FAIL: go to LK_START.
- State OPEN:
  - unlocked=1.
  - code_valid is ignored.
  - relock=1 returns to LOCKED next cycle; fail_cnt stays 0.
- State LK_START: lasts exactly one cycle with cd_start=1 and locked_out=1, then moves to LK_WAIT.
- State LK_WAIT:
  - locked_out=1. code_valid and relock are ignored (no err_pulse, no count change).
  - A wait counter starts at 0 and increments each cycle.
  - rst_all=1: go to LOCKED next cycle, clear fail_cnt, clear the wait counter; locked_out drops in that same next cycle.
  - Wait counter reaching WAIT_MAX-1 without rst_all: set timeout and go to LK_START, which re-pulses cd_start. timeout stays set until reset.
- Latency: code_valid sampled at edge n → unlocked / err_pulse / fail_cnt update visible after edge n (cycle n+1). For the failing code that reaches MAX_FAIL, cd_start is high in cycle n+1.
- rst_all sampling rules:
  - rst_all in LOCKED or OPEN is ignored.
  - rst_all coincident with cd_start (state LK_START) is ignored; it is sampled only in LK_WAIT.
- Back-to-back code_valid (every cycle) is accepted, one evaluation per strobe. A strobe that arrives in the cycle the FSM enters LK_START is ignored.
- The correct code with fail_cnt>0 goes to OPEN and resets fail_cnt to 0, so failures must be consecutive.
- Reset asserted mid-lockout returns to LOCKED at once with fail_cnt=0, timeout=0, cd_start=0. No pending pulse survives reset.
- fail_cnt never exceeds MAX_FAIL and never wraps.

Test Plan:
- Reset, then code_valid with code_in=16'h1234 → next cycle unlocked=1, fail_cnt=0; relock=1 → unlocked=0 one cycle later.
- Codes 16'h0001 and 16'h0002 → err_pulse twice, fail_cnt=2. Then 16'h1234 → unlocked=1, fail_cnt=0.
- Three wrong codes → fail_cnt=3, cd_start high exactly 1 cycle, locked_out=1. code_valid with 16'h1234 during LK_WAIT → ignored. rst_all pulse → locked_out=0, fail_cnt=0 next cycle.
- Lockout with no rst_all (WAIT_MAX=8) → 8 cycles later timeout=1 and a second cd_start pulse. A later rst_all → LOCKED, with timeout still 1.
- rst asserted asynchronously mid-LK_WAIT → all outputs 0 immediately. After release, the correct code unlocks normally.
- rst_all pulsed while LOCKED and again while OPEN → no state or output change.
